// File: rtl/dmem_arbiter.sv
// Shares the single-port 16-bit data memory between the pipeline (P) and interrupt unit (I), splitting 32-bit accesses into two words.
// Narrow ack 3 cycles / wide 4 cycles after the req edge; a loser holds req (P sees stall); DMEM_ARB_RR_EN selects round-robin ties.
module dmem_arbiter #(
    parameter int DEPTH = 2048,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p_req,
    input  logic          p_we,
    input  logic          p_wide,
    input  logic [AW-1:0] p_addr,
    input  logic [31:0]   p_wdata,
    output logic          p_ack,
    output logic [31:0]   p_rdata,
    output logic          p_err,
    input  logic          i_req,
    input  logic          i_we,
    input  logic          i_wide,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic          i_ack,
    output logic [31:0]   i_rdata,
    output logic          i_err,
    output logic          stall,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_W0   = 2'd1,
        S_W1   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [AW:0]   DEPTH_X  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_X    = (AW+1)'(1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    state_t        r_state;
    state_t        w_state_nxt;

    // Latched request, held for the whole access
    logic          r_own_i;
    logic          r_we;
    logic          r_wide;
    logic          r_err;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_wdata_lo;
    logic [31:0]   r_rbuf;

    logic          r_p_ack;
    logic          r_i_ack;
    logic [31:0]   r_p_rdata;
    logic [31:0]   r_i_rdata;
    logic          r_p_err;
    logic          r_i_err;
    logic          r_mem_read;
    logic          r_mem_write;
    logic [AW-1:0] r_mem_addr;
    logic [15:0]   r_mem_wdata;

    logic          w_any;
    logic          w_pick_i;
    logic          w_sel_we;
    logic          w_sel_wide;
    logic [AW-1:0] w_sel_addr;
    logic [31:0]   w_sel_wdata;
    logic [AW:0]   w_sel_ext;
    logic          w_sel_err;

    logic          w_rd_nxt;
    logic          w_wr_nxt;
    logic [AW-1:0] w_maddr_nxt;
    logic [15:0]   w_mwdat_nxt;

`ifdef DMEM_ARB_RR_EN
    logic          r_last_i;
`endif

    // Arbitration and range check on the request that would be granted this cycle
    always_comb begin
        w_any = p_req | i_req;
`ifdef DMEM_ARB_RR_EN
        w_pick_i = i_req & (~p_req | ~r_last_i);
`else
        w_pick_i = i_req;
`endif
        w_sel_we    = w_pick_i ? i_we    : p_we;
        w_sel_wide  = w_pick_i ? i_wide  : p_wide;
        w_sel_addr  = w_pick_i ? i_addr  : p_addr;
        w_sel_wdata = w_pick_i ? i_wdata : p_wdata;
        w_sel_ext   = {1'b0, w_sel_addr};
        // Extended compare so a wide access at the top address still flags after addr+1 wraps
        w_sel_err   = (w_sel_ext >= DEPTH_X) |
                      (w_sel_wide & ((w_sel_ext + ONE_X) >= DEPTH_X));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus next values of the registered memory strobes
    always_comb begin
        w_state_nxt = r_state;
        w_rd_nxt    = 1'b0;
        w_wr_nxt    = 1'b0;
        w_maddr_nxt = r_mem_addr;
        w_mwdat_nxt = r_mem_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_W0;
                    if (!w_sel_err) begin
                        w_rd_nxt    = ~w_sel_we;
                        w_wr_nxt    = w_sel_we;
                        w_maddr_nxt = w_sel_addr;
                        w_mwdat_nxt = w_sel_wide ? w_sel_wdata[31:16] : w_sel_wdata[15:0];
                    end
                end
            end
            S_W0: begin
                w_state_nxt = r_wide ? S_W1 : S_RESP;
                if (r_wide && !r_err) begin
                    w_rd_nxt    = ~r_we;
                    w_wr_nxt    = r_we;
                    w_maddr_nxt = r_addr + ADDR_ONE;
                    w_mwdat_nxt = r_wdata_lo;
                end
            end
            S_W1: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_own_i     <= 1'b0;
            r_we        <= 1'b0;
            r_wide      <= 1'b0;
            r_err       <= 1'b0;
            r_addr      <= '0;
            r_wdata_lo  <= '0;
            r_rbuf      <= '0;
            r_p_ack     <= 1'b0;
            r_i_ack     <= 1'b0;
            r_p_rdata   <= '0;
            r_i_rdata   <= '0;
            r_p_err     <= 1'b0;
            r_i_err     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_read  <= w_rd_nxt;
            r_mem_write <= w_wr_nxt;
            r_mem_addr  <= w_maddr_nxt;
            r_mem_wdata <= w_mwdat_nxt;
            r_p_ack     <= 1'b0;
            r_i_ack     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_own_i    <= w_pick_i;
                        r_we       <= w_sel_we;
                        r_wide     <= w_sel_wide;
                        r_err      <= w_sel_err;
                        r_addr     <= w_sel_addr;
                        r_wdata_lo <= w_sel_wdata[15:0];
                        r_rbuf     <= '0;
                    end
                end
                S_W0: begin
                    // Memory drove rdata on the negedge inside this cycle
                    if (!r_err && !r_we) begin
                        if (r_wide) begin
                            r_rbuf[31:16] <= mem_rdata;
                        end else begin
                            r_rbuf[15:0] <= mem_rdata;
                        end
                    end
                end
                S_W1: begin
                    if (!r_err && !r_we) begin
                        r_rbuf[15:0] <= mem_rdata;
                    end
                end
                S_RESP: begin
                    if (r_own_i) begin
                        r_i_ack   <= 1'b1;
                        r_i_rdata <= r_rbuf;
                        r_i_err   <= r_err;
                    end else begin
                        r_p_ack   <= 1'b1;
                        r_p_rdata <= r_rbuf;
                        r_p_err   <= r_err;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Starts as I so that P wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_i <= 1'b1;
        end else if (r_state == S_IDLE && w_any) begin
            r_last_i <= w_pick_i;
        end
    end
`endif

    assign p_ack     = r_p_ack;
    assign p_rdata   = r_p_rdata;
    assign p_err     = r_p_err;
    assign i_ack     = r_i_ack;
    assign i_rdata   = r_i_rdata;
    assign i_err     = r_i_err;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    // Combinational on p_req so the pipeline freezes in the very cycle it first asks
    assign stall     = p_req & ~r_p_ack & ~rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: memory model on negedge, expected acks queued at drive time and compared when each ack appears.
// Covers narrow/wide access, range errors, contention, mid-access reset and back-to-back pipeline reads.
module tb_dmem_arbiter;

    localparam int DEPTH = 2048;
    localparam int AW    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_req, p_we, p_wide;
    logic [15:0] p_addr;
    logic [31:0] p_wdata;
    logic        p_ack;
    logic [31:0] p_rdata;
    logic        p_err;
    logic        i_req, i_we, i_wide;
    logic [15:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        stall, mem_read, mem_write;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_wide(p_wide), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_ack(p_ack), .p_rdata(p_rdata), .p_err(p_err),
        .i_req(i_req), .i_we(i_we), .i_wide(i_wide), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .stall(stall), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        bit          we;
        bit          wide;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          lat;
    } op_t;

    typedef struct {
        bit          own_i;
        bit          chk_data;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        exp_q[$];
    op_t         p_pend[$];
    logic [31:0] wlog[$];
    logic [15:0] mem     [0:65535] = '{default: 16'h0};
    logic [15:0] ref_mem [0:65535] = '{default: 16'h0};
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          wr0, rd0, acks;

    always @(posedge clk) cyc++;

    // Single-port memory acting on the negedge of the strobe cycle
    always @(negedge clk) begin
        if (mem_write) begin
            mem[mem_addr] = mem_wdata;
            wr_cnt++;
            wlog.push_back({mem_addr, mem_wdata});
        end
        if (mem_read) begin
            mem_rdata = mem[mem_addr];
            rd_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic op_t mkop(input bit we, input bit wide, input logic [15:0] a,
                                 input logic [31:0] d, input int lat);
        op_t o;
        o.we = we; o.wide = wide; o.addr = a; o.wdata = d; o.lat = lat;
        return o;
    endfunction

    function automatic bit is_err(input logic [15:0] a, input bit wide);
        int ai;
        ai = int'(a);
        return (ai >= DEPTH) || (wide && (ai + 1 >= DEPTH));
    endfunction

    task automatic push_exp(input bit own_i, input op_t o);
        exp_t        e;
        logic [15:0] a1;
        a1 = o.addr + 16'd1;
        e.own_i    = own_i;
        e.err      = is_err(o.addr, o.wide);
        e.chk_data = !o.we;
        e.lat      = o.lat;
        e.t0       = cyc;
        if (e.err || o.we) e.rdata = 32'h0;
        else if (o.wide)   e.rdata = {ref_mem[o.addr], ref_mem[a1]};
        else               e.rdata = {16'h0, ref_mem[o.addr]};
        if (o.we && !e.err) begin
            if (o.wide) begin
                ref_mem[o.addr] = o.wdata[31:16];
                ref_mem[a1]     = o.wdata[15:0];
            end else begin
                ref_mem[o.addr] = o.wdata[15:0];
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic drive_p(input op_t o);
        p_req = 1'b1; p_we = o.we; p_wide = o.wide; p_addr = o.addr; p_wdata = o.wdata;
        push_exp(1'b0, o);
    endtask

    task automatic drive_i(input op_t o);
        i_req = 1'b1; i_we = o.we; i_wide = o.wide; i_addr = o.addr; i_wdata = o.wdata;
        push_exp(1'b1, o);
    endtask

    task automatic check_ack(input logic obs_i, input logic [31:0] rdata, input logic err);
        exp_t e;
        chk("ack_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ack_owner", 32'(obs_i), 32'(e.own_i));
            if (e.chk_data) chk("rdata", rdata, e.rdata);
            chk("err", 32'(err), 32'(e.err));
            if (e.lat >= 0) chk("latency", 32'(cyc - e.t0), 32'(e.lat));
        end
    endtask

    task automatic service(input int n, input int budget);
        int got;
        got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            step();
            chk("ack_overlap", 32'(p_ack & i_ack), 32'd0);
            if (p_req && !p_ack) chk("stall_pending", 32'(stall), 32'd1);
            if (p_ack) begin
                check_ack(i_ack, p_rdata, p_err);
                chk("stall_at_ack", 32'(stall), 32'd0);
                got++;
                if (p_pend.size() > 0) drive_p(p_pend.pop_front());
                else p_req = 1'b0;
            end
            if (i_ack) begin
                check_ack(i_ack, i_rdata, i_err);
                got++;
                i_req = 1'b0;
            end
        end
        chk("acks_within_budget", 32'(got), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        p_req = 0; p_we = 0; p_wide = 0; p_addr = '0; p_wdata = '0;
        i_req = 0; i_we = 0; i_wide = 0; i_addr = '0; i_wdata = '0;
        repeat (3) step();
        chk("rst_p_ack",     32'(p_ack), 32'd0);
        chk("rst_i_ack",     32'(i_ack), 32'd0);
        chk("rst_p_rdata",   p_rdata, 32'd0);
        chk("rst_i_rdata",   i_rdata, 32'd0);
        chk("rst_errs",      32'({p_err, i_err}), 32'd0);
        chk("rst_strobes",   32'({mem_read, mem_write}), 32'd0);
        chk("rst_mem_addr",  32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_stall",     32'(stall), 32'd0);
        rst = 1'b0;
        step();

        // Narrow write then read by P
        wr0 = wr_cnt;
        drive_p(mkop(1, 0, 16'h0010, 32'h0000BEEF, 3));
        service(1, 20);
        chk("t1_wr_count", 32'(wr_cnt - wr0), 32'd1);
        chk("t1_wr_log", wlog[wlog.size()-1], 32'h0010BEEF);
        drive_p(mkop(0, 0, 16'h0010, 32'h0, 3));
        service(1, 20);

        // Wide write then wide read by I
        wr0 = wr_cnt;
        drive_i(mkop(1, 1, 16'h0100, 32'h12345678, 4));
        service(1, 20);
        chk("t2_wr_count", 32'(wr_cnt - wr0), 32'd2);
        chk("t2_wr_word0", wlog[wlog.size()-2], 32'h01001234);
        chk("t2_wr_word1", wlog[wlog.size()-1], 32'h01015678);
        drive_i(mkop(0, 1, 16'h0100, 32'h0, 4));
        service(1, 20);

        // Range boundaries
        drive_p(mkop(1, 0, 16'h07FF, 32'h0000A5A5, 3));
        service(1, 20);
        drive_p(mkop(0, 0, 16'h07FF, 32'h0, 3));
        service(1, 20);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        drive_p(mkop(0, 1, 16'h07FF, 32'h0, 4));
        service(1, 20);
        drive_p(mkop(1, 0, 16'h0800, 32'h0000DEAD, 3));
        service(1, 20);
        drive_i(mkop(0, 1, 16'hFFFF, 32'h0, 4));
        service(1, 20);
        chk("t3_no_read_strobe",  32'(rd_cnt - rd0), 32'd0);
        chk("t3_no_write_strobe", 32'(wr_cnt - wr0), 32'd0);
        chk("t3_mem_800_intact",  32'(mem[16'h0800]), 32'd0);

        // Reset taken on the edge that would start word 1 of a wide write
        i_req = 1'b1; i_we = 1'b1; i_wide = 1'b1; i_addr = 16'h0200; i_wdata = 32'hAAAA5555;
        step();
        chk("t5_w0_write", 32'(mem_write), 32'd1);
        chk("t5_w0_addr",  32'(mem_addr), 32'h0200);
        rst = 1'b1;
        step();
        chk("t5_strobes_dropped", 32'({mem_read, mem_write}), 32'd0);
        chk("t5_no_ack_in_reset", 32'({p_ack, i_ack}), 32'd0);
        rst = 1'b0;
        i_req = 1'b0;
        acks = 0;
        repeat (6) begin
            step();
            if (p_ack || i_ack) acks++;
        end
        chk("t5_no_ack_after", 32'(acks), 32'd0);
        chk("t5_word0_written", 32'(mem[16'h0200]), 32'h0000AAAA);
        chk("t5_word1_untouched", 32'(mem[16'h0201]), 32'd0);
        ref_mem[16'h0200] = 16'hAAAA;

        // Simultaneous requests straight after reset
`ifdef DMEM_ARB_RR_EN
        drive_p(mkop(0, 0, 16'h0010, 32'h0, 3));
        drive_i(mkop(0, 0, 16'h0100, 32'h0, 6));
`else
        drive_i(mkop(0, 0, 16'h0100, 32'h0, 3));
        drive_p(mkop(0, 0, 16'h0010, 32'h0, 6));
`endif
        service(2, 30);

        // Aborted access left the FSM idle and only word 0 in memory
        drive_i(mkop(0, 1, 16'h0200, 32'h0, 4));
        service(1, 20);

        // Back-to-back pipeline reads at 0,1,2
        drive_p(mkop(1, 1, 16'h0000, 32'h11112222, 4));
        service(1, 20);
        drive_p(mkop(1, 0, 16'h0002, 32'h00003333, 3));
        service(1, 20);
        drive_p(mkop(0, 0, 16'h0000, 32'h0, 3));
        p_pend.push_back(mkop(0, 0, 16'h0001, 32'h0, 3));
        p_pend.push_back(mkop(0, 0, 16'h0002, 32'h0, 3));
        service(3, 40);
        step();
        chk("t6_stall_after_last", 32'(stall), 32'd0);
        chk("t6_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
